// File: rtl/ioctl_download_tx.sv
// rtl/ioctl_download_tx.sv - ioctl download initiator: walks a byte source and strobes bytes to a receiver
module ioctl_download_tx #(
   parameter int SETUP_CYCLES = 4,
   parameter int WR_GAP       = 3,
   parameter int TAIL_CYCLES  = 4
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        start,
   input  logic [25:0] file_size,
   input  logic [7:0]  file_index,
   output logic        src_rd,
   output logic [24:0] src_addr,
   input  logic [7:0]  src_data,
   input  logic        src_valid,
   output logic        ioctl_download,
   output logic [7:0]  ioctl_index,
   output logic        ioctl_wr,
   output logic [24:0] ioctl_addr,
   output logic [7:0]  ioctl_dout,
   input  logic        ioctl_wait,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      IDLE, SETUP, FETCH, WAITD, WRITE, GAP, TAIL, FIN
   } state_t;

   localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYCLES - 1);
   localparam logic [15:0] GAP_LAST   = 16'((WR_GAP > 0) ? WR_GAP - 1 : 0);
   localparam logic [15:0] TAIL_LAST  = 16'(TAIL_CYCLES - 1);

   state_t      state;
   logic [15:0] cnt;
   logic [24:0] n;
   logic [24:0] last;

   // The receiver's stall must be able to veto the strobe in the very cycle WRITE is entered
   assign ioctl_wr = (state == WRITE) && !ioctl_wait;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         n              <= '0;
         last           <= '0;
         src_rd         <= 1'b0;
         src_addr       <= '0;
         ioctl_download <= 1'b0;
         ioctl_index    <= '0;
         ioctl_addr     <= '0;
         ioctl_dout     <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         done   <= 1'b0;
         src_rd <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  ioctl_index <= file_index;
                  if (file_size == 26'd0) begin
                     state <= FIN;
                     done  <= 1'b1;
                  end else begin
                     state          <= SETUP;
                     cnt            <= '0;
                     n              <= '0;
                     // sizes of 2^25 and above all end at the top of the 25-bit space
                     last           <= file_size[25] ? 25'h1FF_FFFF : 25'(file_size - 26'd1);
                     ioctl_download <= 1'b1;
                     busy           <= 1'b1;
                  end
               end
            end
            SETUP: begin
               if (cnt == SETUP_LAST) begin
                  state    <= FETCH;
                  src_rd   <= 1'b1;
                  src_addr <= n;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            FETCH: begin
               state <= WAITD;
            end
            WAITD: begin
               if (src_valid) begin
                  ioctl_dout <= src_data;
                  ioctl_addr <= n;
                  state      <= WRITE;
               end
            end
            WRITE: begin
               if (!ioctl_wait) begin
                  cnt <= '0;
                  if (n == last) begin
                     state <= TAIL;
                  end else begin
                     n <= n + 25'd1;
                     if (WR_GAP == 0) begin
                        state    <= FETCH;
                        src_rd   <= 1'b1;
                        src_addr <= n + 25'd1;
                     end else begin
                        state <= GAP;
                     end
                  end
               end
            end
            GAP: begin
               if (cnt == GAP_LAST) begin
                  state    <= FETCH;
                  src_rd   <= 1'b1;
                  src_addr <= n;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            TAIL: begin
               if (cnt == TAIL_LAST) begin
                  state          <= FIN;
                  ioctl_download <= 1'b0;
                  busy           <= 1'b0;
                  done           <= 1'b1;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            FIN: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ioctl_download_tx.sv
// tb/tb_ioctl_download_tx.sv - scoreboard bench for ioctl_download_tx
module tb_ioctl_download_tx;

   typedef struct {
      int         c;
      logic [24:0] a;
      logic [7:0]  d;
      logic [7:0]  i;
   } wr_t;

   typedef struct {
      int c;
      int dl;
   } dn_t;

   logic clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   logic reset = 1'b1;
   int   cyc   = 0;
   int   tests = 0;
   int   fails = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   // DUT A: default timing, 1-cycle source
   logic        a_start = 1'b0;
   logic [25:0] a_size  = '0;
   logic [7:0]  a_idx   = '0;
   logic        a_src_rd;
   logic [24:0] a_src_addr;
   logic [7:0]  a_src_data  = '0;
   logic        a_src_valid = 1'b0;
   logic        a_dl, a_wr, a_busy, a_done;
   logic [7:0]  a_index, a_dout;
   logic [24:0] a_addr;
   logic        a_wait = 1'b0;

   // DUT B: WR_GAP=0, 5-cycle source
   logic        b_start = 1'b0;
   logic [25:0] b_size  = '0;
   logic [7:0]  b_idx   = '0;
   logic        b_src_rd;
   logic [24:0] b_src_addr;
   logic [7:0]  b_src_data  = '0;
   logic        b_src_valid = 1'b0;
   logic        b_dl, b_wr, b_busy, b_done;
   logic [7:0]  b_index, b_dout;
   logic [24:0] b_addr;
   logic        b_wait = 1'b0;

   ioctl_download_tx u_dut_a (
      .clk_sys(clk_sys), .reset(reset), .start(a_start), .file_size(a_size), .file_index(a_idx),
      .src_rd(a_src_rd), .src_addr(a_src_addr), .src_data(a_src_data), .src_valid(a_src_valid),
      .ioctl_download(a_dl), .ioctl_index(a_index), .ioctl_wr(a_wr), .ioctl_addr(a_addr),
      .ioctl_dout(a_dout), .ioctl_wait(a_wait), .busy(a_busy), .done(a_done)
   );

   ioctl_download_tx #(.SETUP_CYCLES(4), .WR_GAP(0), .TAIL_CYCLES(4)) u_dut_b (
      .clk_sys(clk_sys), .reset(reset), .start(b_start), .file_size(b_size), .file_index(b_idx),
      .src_rd(b_src_rd), .src_addr(b_src_addr), .src_data(b_src_data), .src_valid(b_src_valid),
      .ioctl_download(b_dl), .ioctl_index(b_index), .ioctl_wr(b_wr), .ioctl_addr(b_addr),
      .ioctl_dout(b_dout), .ioctl_wait(b_wait), .busy(b_busy), .done(b_done)
   );

   wr_t qa[$];
   wr_t qb[$];
   dn_t qda[$];
   dn_t qdb[$];
   int  qra[$];
   int  qrb[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Byte source models: return addr^0xA5 a fixed latency after src_rd
   logic        a_pend = 1'b0, b_pend = 1'b0;
   int          a_due = 0, b_due = 0;
   logic [24:0] a_paddr = '0, b_paddr = '0;

   always @(negedge clk_sys) begin
      if (reset) begin
         a_pend = 1'b0;
         b_pend = 1'b0;
      end else begin
         if (a_src_valid) a_pend = 1'b0;
         if (b_src_valid) b_pend = 1'b0;
         if (a_src_rd) begin a_pend = 1'b1; a_due = cyc + 1; a_paddr = a_src_addr; end
         if (b_src_rd) begin b_pend = 1'b1; b_due = cyc + 5; b_paddr = b_src_addr; end
      end
   end

   always @(posedge clk_sys) begin
      #1;
      a_src_valid = a_pend && (cyc == a_due);
      a_src_data  = a_src_valid ? (a_paddr[7:0] ^ 8'hA5) : 8'h3C;
      b_src_valid = b_pend && (cyc == b_due);
      b_src_data  = b_src_valid ? (b_paddr[7:0] ^ 8'hA5) : 8'h3C;
   end

   // Monitors with a receiver model that reports size = last addr + 1 on download fall
   int          dl_a = 0, dl_b = 0;
   logic        pw_a = 1'b0, pd_a = 1'b0, pw_b = 1'b0, pd_b = 1'b0;
   logic [24:0] last_a = '0, last_b = '0;
   wr_t         ea, eb;
   dn_t         da, db;
   int          ra, rb;

   always @(negedge clk_sys) begin
      if (reset) dl_a = 0; else if (a_dl) dl_a++;
      if (a_wr) begin
         chk("a_wr_not_back_to_back", 64'(pw_a), 64'd0);
         if (qa.size() == 0) chk("a_wr_unexpected", 64'd1, 64'd0);
         else begin
            ea = qa.pop_front();
            chk("a_wr_cycle", 64'(cyc), 64'(ea.c));
            chk("a_wr_addr", 64'(a_addr), 64'(ea.a));
            chk("a_wr_dout", 64'(a_dout), 64'(ea.d));
            chk("a_wr_index", 64'(a_index), 64'(ea.i));
         end
         last_a = a_addr;
      end
      if (a_done) begin
         if (qda.size() == 0) chk("a_done_unexpected", 64'd1, 64'd0);
         else begin
            da = qda.pop_front();
            chk("a_done_cycle", 64'(cyc), 64'(da.c));
            chk("a_download_len", 64'(dl_a), 64'(da.dl));
         end
         dl_a = 0;
      end
      if (pd_a && !a_dl) begin
         if (qra.size() == 0) chk("a_fall_unexpected", 64'd1, 64'd0);
         else begin
            ra = qra.pop_front();
            chk("a_rx_size", 64'(last_a) + 64'd1, 64'(ra));
         end
      end
      pw_a = a_wr;
      pd_a = a_dl;

      if (reset) dl_b = 0; else if (b_dl) dl_b++;
      if (b_wr) begin
         chk("b_wr_not_back_to_back", 64'(pw_b), 64'd0);
         if (qb.size() == 0) chk("b_wr_unexpected", 64'd1, 64'd0);
         else begin
            eb = qb.pop_front();
            chk("b_wr_cycle", 64'(cyc), 64'(eb.c));
            chk("b_wr_addr", 64'(b_addr), 64'(eb.a));
            chk("b_wr_dout", 64'(b_dout), 64'(eb.d));
            chk("b_wr_index", 64'(b_index), 64'(eb.i));
         end
         last_b = b_addr;
      end
      if (b_done) begin
         if (qdb.size() == 0) chk("b_done_unexpected", 64'd1, 64'd0);
         else begin
            db = qdb.pop_front();
            chk("b_done_cycle", 64'(cyc), 64'(db.c));
            chk("b_download_len", 64'(dl_b), 64'(db.dl));
         end
         dl_b = 0;
      end
      if (pd_b && !b_dl) begin
         if (qrb.size() == 0) chk("b_fall_unexpected", 64'd1, 64'd0);
         else begin
            rb = qrb.pop_front();
            chk("b_rx_size", 64'(last_b) + 64'd1, 64'(rb));
         end
      end
      pw_b = b_wr;
      pd_b = b_dl;
   end

   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   task automatic start_a(input logic [25:0] size, input logic [7:0] idx, output int s);
      @(posedge clk_sys);
      #1;
      s       = cyc;
      a_size  = size;
      a_idx   = idx;
      a_start = 1'b1;
      @(posedge clk_sys);
      #1;
      a_start = 1'b0;
   endtask

   task automatic push_a(input int c, input logic [24:0] a, input logic [7:0] d, input logic [7:0] i);
      wr_t e;
      e.c = c; e.a = a; e.d = d; e.i = i;
      qa.push_back(e);
   endtask

   task automatic push_da(input int c, input int dl);
      dn_t e;
      e.c = c; e.dl = dl;
      qda.push_back(e);
   endtask

   initial begin
      int  s;
      wr_t e;
      dn_t d;

      repeat (3) @(posedge clk_sys);
      #1;
      reset = 1'b0;
      @(negedge clk_sys);
      chk("reset_a_ctrl", 64'({a_dl, a_wr, a_busy, a_done, a_src_rd}), 64'd0);
      chk("reset_b_ctrl", 64'({b_dl, b_wr, b_busy, b_done, b_src_rd}), 64'd0);
      chk("reset_a_data", 64'({a_addr, a_dout, a_index}), 64'd0);

      // size 4, idx 2: strobes every 6 cycles, data A5 A4 A7 A6
      start_a(26'd4, 8'h02, s);
      push_a(s + 7,  25'd0, 8'hA5, 8'h02);
      push_a(s + 13, 25'd1, 8'hA4, 8'h02);
      push_a(s + 19, 25'd2, 8'hA7, 8'h02);
      push_a(s + 25, 25'd3, 8'hA6, 8'h02);
      push_da(s + 30, 29);
      qra.push_back(4);
      goto(s + 2);
      chk("busy_during_t1", 64'(a_busy), 64'd1);
      goto(s + 34);
      chk("index_retained", 64'(a_index), 64'h02);
      chk("addr_retained", 64'(a_addr), 64'd3);

      // size 3 with a 10-cycle stall at the second WRITE
      start_a(26'd3, 8'h11, s);
      push_a(s + 7,  25'd0, 8'hA5, 8'h11);
      push_a(s + 23, 25'd1, 8'hA4, 8'h11);
      push_a(s + 29, 25'd2, 8'hA7, 8'h11);
      push_da(s + 34, 33);
      qra.push_back(3);
      goto(s + 13);
      a_wait = 1'b1;
      goto(s + 18);
      @(negedge clk_sys);
      chk("stall_addr_mid", 64'(a_addr), 64'd1);
      chk("stall_dout_mid", 64'(a_dout), 64'hA4);
      goto(s + 22);
      @(negedge clk_sys);
      chk("stall_addr_end", 64'(a_addr), 64'd1);
      chk("stall_dout_end", 64'(a_dout), 64'hA4);
      chk("stall_no_wr", 64'(a_wr), 64'd0);
      goto(s + 23);
      a_wait = 1'b0;
      goto(s + 38);

      // size 0: done one cycle after start, download never rises
      start_a(26'd0, 8'h09, s);
      push_da(s + 1, 0);
      goto(s + 3);
      chk("size0_busy", 64'(a_busy), 64'd0);

      // size 8 with an ignored second start at byte 3
      start_a(26'd8, 8'h03, s);
      for (int k = 0; k < 8; k++) push_a(s + 7 + 6 * k, 25'(k), 8'(k) ^ 8'hA5, 8'h03);
      push_da(s + 54, 53);
      qra.push_back(8);
      goto(s + 25);
      a_size  = 26'd2;
      a_idx   = 8'h44;
      a_start = 1'b1;
      goto(s + 26);
      a_start = 1'b0;
      @(negedge clk_sys);
      chk("busy_after_ignored_start", 64'(a_busy), 64'd1);
      goto(s + 58);

      // reset after the second strobe of a size 6 transfer
      start_a(26'd6, 8'h06, s);
      push_a(s + 7,  25'd0, 8'hA5, 8'h06);
      push_a(s + 13, 25'd1, 8'hA4, 8'h06);
      qra.push_back(2);
      goto(s + 14);
      reset = 1'b1;
      goto(s + 15);
      reset = 1'b0;
      @(negedge clk_sys);
      chk("midreset_ctrl", 64'({a_dl, a_wr, a_busy, a_done, a_src_rd}), 64'd0);
      chk("midreset_data", 64'({a_addr, a_dout, a_index}), 64'd0);
      goto(s + 35);
      start_a(26'd1, 8'h05, s);
      push_a(s + 7, 25'd0, 8'hA5, 8'h05);
      push_da(s + 12, 11);
      qra.push_back(1);
      goto(s + 16);

      // WR_GAP=0 with 5-cycle source latency: strobes 7 cycles apart
      @(posedge clk_sys);
      #1;
      s       = cyc;
      b_size  = 26'd2;
      b_idx   = 8'h21;
      b_start = 1'b1;
      @(posedge clk_sys);
      #1;
      b_start = 1'b0;
      e.c = s + 11; e.a = 25'd0; e.d = 8'hA5; e.i = 8'h21; qb.push_back(e);
      e.c = s + 18; e.a = 25'd1; e.d = 8'hA4; e.i = 8'h21; qb.push_back(e);
      d.c = s + 23; d.dl = 22; qdb.push_back(d);
      qrb.push_back(2);
      goto(s + 27);

      chk("qa_drained", 64'(qa.size()), 64'd0);
      chk("qda_drained", 64'(qda.size()), 64'd0);
      chk("qra_drained", 64'(qra.size()), 64'd0);
      chk("qb_drained", 64'(qb.size()), 64'd0);
      chk("qdb_drained", 64'(qdb.size()), 64'd0);
      chk("qrb_drained", 64'(qrb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
